// File: rtl/multi_edge_detect.sv
// Multi-channel edge detector: per-channel synchroniser, stability filter,
// selectable rising/falling edge strobe (active low) and saturating edge counter.
module multi_edge_detect #(
   parameter int CH          = 4,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_W      = 4,
   parameter int CNT_W       = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [CH-1:0]         pluse,
   input  logic [FILT_W-1:0]     filt_len,
   input  logic [2*CH-1:0]       mode,
   input  logic                  cnt_clr,
   output logic [CH-1:0]         edge_n,
   output logic [CH-1:0]         level,
   output logic [CH*CNT_W-1:0]   edge_cnt,
   output logic [CH-1:0]         overflow
);

   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [FILT_W:0]   FILT_ONE = {{FILT_W{1'b0}}, 1'b1};

   genvar g;
   generate
      for (g = 0; g < CH; g++) begin : g_ch
         logic [SYNC_STAGES-1:0] sync_r;
         logic                   sync_s;
         logic [FILT_W-1:0]      fcnt_r;
         logic [FILT_W-1:0]      fcnt_nxt_s;
         logic [FILT_W:0]        fcnt_inc_s;
         logic                   level_r;
         logic                   level_nxt_s;
         logic                   level_d_r;
         logic                   rise_s;
         logic                   fall_s;
         logic                   event_s;
         logic                   edge_n_r;
         logic [CNT_W-1:0]       cnt_r;
         logic [CNT_W-1:0]       cnt_nxt_s;
         logic                   ovf_r;
         logic                   ovf_nxt_s;

         assign sync_s = sync_r[SYNC_STAGES-1];

         // Filter, edge qualification and counter next-state for this channel
         always_comb begin
            fcnt_inc_s  = {1'b0, fcnt_r} + FILT_ONE;
            fcnt_nxt_s  = fcnt_r;
            level_nxt_s = level_r;
            cnt_nxt_s   = cnt_r;
            ovf_nxt_s   = ovf_r;

            // Compare one bit wider so a shortened filt_len releases at once
            if (sync_s == level_r) begin
               fcnt_nxt_s = {FILT_W{1'b0}};
            end else if (fcnt_inc_s >= {1'b0, filt_len}) begin
               level_nxt_s = sync_s;
               fcnt_nxt_s  = {FILT_W{1'b0}};
            end else begin
               fcnt_nxt_s = fcnt_inc_s[FILT_W-1:0];
            end

            rise_s  = level_r & ~level_d_r;
            fall_s  = ~level_r & level_d_r;
            event_s = (mode[2*g] & rise_s) | (mode[2*g+1] & fall_s);

            if (cnt_clr) begin
               cnt_nxt_s = event_s ? CNT_ONE : {CNT_W{1'b0}};
               ovf_nxt_s = 1'b0;
            end else if (event_s) begin
               if (cnt_r == CNT_MAX) begin
                  cnt_nxt_s = cnt_r;
                  ovf_nxt_s = 1'b1;
               end else begin
                  cnt_nxt_s = cnt_r + CNT_ONE;
                  ovf_nxt_s = ovf_r;
               end
            end else begin
               cnt_nxt_s = cnt_r;
               ovf_nxt_s = ovf_r;
            end
         end

         // Channel state registers; idle level is high to match encoder lines
         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               sync_r    <= {SYNC_STAGES{1'b1}};
               fcnt_r    <= {FILT_W{1'b0}};
               level_r   <= 1'b1;
               level_d_r <= 1'b1;
               edge_n_r  <= 1'b1;
               cnt_r     <= {CNT_W{1'b0}};
               ovf_r     <= 1'b0;
            end else begin
               sync_r    <= {sync_r[SYNC_STAGES-2:0], pluse[g]};
               fcnt_r    <= fcnt_nxt_s;
               level_r   <= level_nxt_s;
               level_d_r <= level_r;
               edge_n_r  <= ~event_s;
               cnt_r     <= cnt_nxt_s;
               ovf_r     <= ovf_nxt_s;
            end
         end

         assign edge_n[g]                  = edge_n_r;
         assign level[g]                   = level_r;
         assign edge_cnt[g*CNT_W +: CNT_W] = cnt_r;
         assign overflow[g]                = ovf_r;
      end
   endgenerate

endmodule

// File: doc/multi_edge_detect.md
Name: multi_edge_detect

Overview:
Parametrised, multi-channel successor to the single-channel rising-edge detector used on encoder inputs. Each channel synchronises an asynchronous input, removes glitches with a programmable stability filter, detects rising/falling/both edges per channel, and emits a one-cycle active-low edge strobe. Each channel also keeps a saturating edge counter with sticky overflow for encoder pulse counting and diagnostics.

Parameters:
CH, 4, number of independent input channels (>=1)
SYNC_STAGES, 2, synchroniser flop depth per channel (>=2)
FILT_W, 4, width of filter length input and per-channel stability counter
CNT_W, 16, width of each per-channel edge counter

Ports:
clock  input  1  single system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
pluse  input  CH  asynchronous raw inputs, bit i = channel i
filt_len  input  FILT_W  required consecutive stable cycles before filtered level changes; 0 or 1 = filter bypass
mode  input  2*CH  per channel [2i+1:2i]: 00 disabled, 01 rising, 10 falling, 11 both
cnt_clr  input  1  synchronous clear of all edge counters and overflow flags
edge_n  output  CH  active-low one-cycle edge strobe per channel
level  output  CH  filtered, synchronised level per channel
edge_cnt  output  CH*CNT_W  per-channel saturating edge count, channel i at [i*CNT_W +: CNT_W]
overflow  output  CH  sticky: edge occurred while counter saturated

Behaviour:
- Reset (reset=0, asynchronous): all sync flops=1, level=all 1, level_d=all 1, filter counters=0, edge_n=all 1 (inactive), edge_cnt=0, overflow=0.
- Sync: pluse[i] passes through SYNC_STAGES flops; the last stage output is sync[i].
- Filter per channel: if sync==level, fcnt<=0. If sync!=level and fcnt+1 >= filt_len, level<=sync and fcnt<=0; otherwise fcnt<=fcnt+1. The comparison is done at FILT_W+1 bits, with no wrap.
- Glitches shorter than max(filt_len,1) cycles at the sync output never change level.
- filt_len changed mid-count: the new value applies immediately. If fcnt+1 already >= the new value, level updates on the next clock.
- Edge qualify: level_d is level registered. rise = level & ~level_d; fall = ~level & level_d. Event = (mode bit0 & rise) | (mode bit1 & fall).
- edge_n is registered and goes low for exactly one cycle per event, with no merging. Consecutive edges are at least max(filt_len,1) cycles apart.
- Latency from a pluse change, stable and set up before clock edge 0, to edge_n low: SYNC_STAGES + max(filt_len,1) + 1 clock edges. Example: 4 edges at SYNC_STAGES=2, filt_len=0.
- level tracking is independent of mode. A mode change takes effect on the next event evaluation and never generates a spurious edge. mode=00 suppresses both edge_n and counting.
- Counter: on each event, edge_cnt[i] increments, saturating at 2^CNT_W-1. An event at saturation holds the count and sets overflow[i].
- cnt_clr=1: all edge_cnt<=0 and overflow<=0, except a channel with an event in the same cycle, whose count becomes 1 (overflow still cleared). edge_n is unaffected by cnt_clr.
- Reset release with an input held low: level starts at 1, so a falling edge is detected after the normal latency if enabled. This is intentional and matches idle-high encoder lines.
- Reset asserted mid-filter or mid-strobe: all state returns to reset values immediately, and no partial strobe completes.
- Channels are fully independent, and simultaneous events on all channels are all reported in the same cycle.

Test Plan:
- Reset check: reset=0 with random pluse -> edge_n=4'b1111, level=4'b1111, edge_cnt=0, overflow=0. Release reset with pluse=4'b1111 -> no strobe for 20 cycles.
- Basic rising, filt_len=0, mode=01 on ch0: pluse[0] 1->0->1, each level held 10 cycles -> one edge_n[0] low pulse exactly 4 edges after the 0->1 change; none on the falling edge; edge_cnt ch0=1.
- Both edges with filter, filt_len=5, mode=11: a 3-cycle low glitch -> no level change, no strobe. A 10-cycle low then high -> two strobes, each SYNC_STAGES+5+1 edges after its transition; count=2.
- Mode gating: ch1 mode=00 and ch2 mode=10 with identical toggling -> ch1 has no strobes and count 0; ch2 strobes only on falling edges; level still tracks on both.
- Saturation, CNT_W=4: 17 rising edges on ch3 -> edge_cnt ch3=15, overflow[3]=1. Then cnt_clr in the same cycle as an event -> count=1, overflow=0.
- Mid-operation reset: assert reset during the filter count and again during an edge_n low cycle -> outputs return to reset values asynchronously. After release, a low input yields one falling strobe when mode bit1=1.
